// File: rtl/alto_control_pkg.sv
// ---------------------------------------------------------------------------
// alto_control_pkg
// Shared constants and types for the Alto microcode task-control logic.
//   ALTO_NTASKS   number of microcode tasks
//   ALTO_TASK_W   width of a task number
//   ALTO_EMU_TASK emulator task index (always requests)
//   task_id_t     task number
//   task_vec_t    one bit per task
// ---------------------------------------------------------------------------
package alto_control_pkg;

  localparam int ALTO_NTASKS   = 16;
  localparam int ALTO_TASK_W   = 4;
  localparam int ALTO_EMU_TASK = 0;

  typedef logic [ALTO_TASK_W-1:0] task_id_t;
  typedef logic [ALTO_NTASKS-1:0] task_vec_t;

endpackage : alto_control_pkg

// File: rtl/alto_control_wakeup_slot.sv
// ---------------------------------------------------------------------------
// alto_control_wakeup_slot
// Wakeup state for one non-emulator task: sticky pulse latch, post-BLOCK
// hold-off down-counter and the registered request bit.
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   wake_level_i   level wakeup for this task
//   wake_pulse_i   one-cycle wakeup strobe for this task
//   clr_i          this task executes BLOCK this cycle
//   request_d_o    next value of the request bit (for the any-device flop)
//   request_o      registered request bit
// ---------------------------------------------------------------------------
module alto_control_wakeup_slot #(
  parameter int HOLDOFF = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wake_level_i,
  input  logic wake_pulse_i,
  input  logic clr_i,
  output logic request_d_o,
  output logic request_o
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] HOLDOFF_LD = CNT_W'(HOLDOFF);

  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             request_q;
  logic             lvl_ok;

  // A pulse in the same cycle as BLOCK wins, so a wakeup arriving just as the
  // task gives up the processor is never lost. The level is masked while the
  // hold-off counter runs and in the BLOCK cycle itself.
  always_comb begin
    sticky_d = wake_pulse_i | (sticky_q & ~clr_i);
    cnt_d    = '0;
    if (clr_i) begin
      cnt_d = HOLDOFF_LD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    lvl_ok      = wake_level_i & (cnt_q == '0) & ~clr_i;
    request_d_o = sticky_d | lvl_ok;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
      request_q <= 1'b0;
    end else begin
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
      request_q <= request_d_o;
    end
  end

  assign request_o = request_q;

endmodule : alto_control_wakeup_slot

// File: rtl/alto_control_wakeup.sv
// ---------------------------------------------------------------------------
// alto_control_wakeup
// Per-task wakeup request register feeding the microcode task switcher's
// priority encoder. Device wakeups (level and pulse) set a task's request;
// BLOCK by the running task clears it and starts a short hold-off during
// which that task's level wakeup is ignored. The emulator always requests.
// Ports:
//   clk_i           system clock
//   rst_i           asynchronous active-high reset
//   wake_level_i    level wakeups, one per task
//   wake_pulse_i    one-cycle wakeup strobes, one per task (latched sticky)
//   block_i         running task executes BLOCK this cycle
//   active_task_i   currently running task
//   task_request_o  registered request vector
//   any_device_o    registered OR of all non-emulator request bits
// ---------------------------------------------------------------------------
module alto_control_wakeup
  import alto_control_pkg::*;
#(
  parameter int NTASKS   = ALTO_NTASKS,
  parameter int TASK_W   = ALTO_TASK_W,
  parameter int EMU_TASK = ALTO_EMU_TASK,
  parameter int HOLDOFF  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NTASKS-1:0] wake_level_i,
  input  logic [NTASKS-1:0] wake_pulse_i,
  input  logic              block_i,
  input  logic [TASK_W-1:0] active_task_i,
  output logic [NTASKS-1:0] task_request_o,
  output logic              any_device_o
);

  logic [NTASKS-1:0] req_vec;
  logic [NTASKS-1:0] req_next;
  logic              any_device_q;

  genvar n;
  generate
    for (n = 0; n < NTASKS; n++) begin : g_task
      if (n == EMU_TASK) begin : g_emu
        // The emulator has no wakeup state; BLOCK by it is simply ignored.
        assign req_vec[n]  = 1'b1;
        assign req_next[n] = 1'b0;
      end else begin : g_slot
        logic clr;
        assign clr = block_i & (active_task_i == TASK_W'(n));

        alto_control_wakeup_slot #(
          .HOLDOFF (HOLDOFF)
        ) u_slot (
          .clk_i        (clk_i),
          .rst_i        (rst_i),
          .wake_level_i (wake_level_i[n]),
          .wake_pulse_i (wake_pulse_i[n]),
          .clr_i        (clr),
          .request_d_o  (req_next[n]),
          .request_o    (req_vec[n])
        );
      end
    end
  endgenerate

  // Built from the slots' next values so any_device_o lines up with the
  // request vector on the same edge rather than lagging it by a cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      any_device_q <= 1'b0;
    end else begin
      any_device_q <= |req_next;
    end
  end

  assign task_request_o = req_vec;
  assign any_device_o   = any_device_q;

endmodule : alto_control_wakeup

// File: tb/tb_alto_control_wakeup.sv
// ---------------------------------------------------------------------------
// tb_alto_control_wakeup
// Self-checking bench for alto_control_wakeup: reset, table-driven vectors,
// hand-written hold-off sequences and randomized traffic against a
// behavioural model that tracks "last BLOCK cycle" per task.
// ---------------------------------------------------------------------------
module tb_alto_control_wakeup;
  import alto_control_pkg::*;

  localparam int H = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] wake_level_i;
  logic [15:0] wake_pulse_i;
  logic        block_i;
  logic [3:0]  active_task_i;
  logic [15:0] task_request_o;
  logic        any_device_o;

  int checks = 0;
  int errors = 0;

  alto_control_wakeup #(
    .HOLDOFF (H)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wake_level_i   (wake_level_i),
    .wake_pulse_i   (wake_pulse_i),
    .block_i        (block_i),
    .active_task_i  (active_task_i),
    .task_request_o (task_request_o),
    .any_device_o   (any_device_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: a task is pending after a pulse until it blocks; a level
  // counts only if the last BLOCK of that task was more than H cycles ago.
  bit          modelPending[16];
  int          modelLastBlock[16];
  int          modelCycle = 0;
  logic [15:0] modelVec;

  function automatic void modelReset();
    for (int n = 0; n < 16; n++) begin
      modelPending[n]   = 1'b0;
      modelLastBlock[n] = -1000;
    end
    modelVec = 16'h0001;
  endfunction

  function automatic void modelStep(logic [15:0] lvl, logic [15:0] pulse,
                                    logic blk, logic [3:0] tsk);
    logic [15:0] v;
    v = 16'h0001;
    for (int n = 1; n < 16; n++) begin
      bit clr;
      bit lvlOk;
      clr   = blk && (int'(tsk) == n);
      lvlOk = lvl[n] && !clr && ((modelCycle - modelLastBlock[n]) > H);
      modelPending[n] = pulse[n] || (modelPending[n] && !clr);
      v[n] = modelPending[n] || lvlOk;
      if (clr) modelLastBlock[n] = modelCycle;
    end
    modelVec = v;
    modelCycle++;
  endfunction

  typedef struct {
    logic [15:0] level;
    logic [15:0] pulse;
    logic        blk;
    logic [3:0]  tsk;
    logic [15:0] expVec;
    logic        expAny;
  } vector_t;

  vector_t vectors[$];

  task automatic applyStimulus(input logic [15:0] lvl, input logic [15:0] pulse,
                               input logic blk, input logic [3:0] tsk);
    wake_level_i  = lvl;
    wake_pulse_i  = pulse;
    block_i       = blk;
    active_task_i = tsk;
    @(posedge clk_i);
    modelStep(lvl, pulse, blk, tsk);
    @(negedge clk_i);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] expVec,
                             input logic expAny);
    checks++;
    if (task_request_o !== expVec || any_device_o !== expAny) begin
      errors++;
      $display("[TB] FAIL %s: got task_request_o=%h any_device_o=%b, expected %h %b",
               name, task_request_o, any_device_o, expVec, expAny);
    end
  endtask

  task automatic asyncReset(input string name);
    #2 rst_i = 1'b1;
    #1 checkOutput(name, 16'h0001, 1'b0);
    modelReset();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  function automatic void addVec(logic [15:0] l, logic [15:0] p, logic b,
                                 logic [3:0] t, logic [15:0] ev);
    vector_t v;
    v.level = l; v.pulse = p; v.blk = b; v.tsk = t;
    v.expVec = ev; v.expAny = |ev[15:1];
    vectors.push_back(v);
  endfunction

  initial begin
    logic [15:0] rl, rp;
    logic        rb;
    logic [3:0]  rt;

    rst_i = 1'b1;
    wake_level_i = '0; wake_pulse_i = '0; block_i = 1'b0; active_task_i = '0;
    modelReset();
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("reset_state", 16'h0001, 1'b0);
    rst_i = 1'b0;

    // T1: reset asserted mid-run with task 5 sticky
    applyStimulus(16'h0000, 16'h0020, 1'b0, 4'd0);
    checkOutput("t1_sticky5", 16'h0021, 1'b1);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 4'd0);
    checkOutput("t1_sticky5_hold", 16'h0021, 1'b1);
    asyncReset("t1_async_reset");
    applyStimulus(16'h0000, 16'h0000, 1'b0, 4'd0);
    checkOutput("t1_after_release", 16'h0001, 1'b0);

    // T2 pulse, T4 collision, T5 emulator, T6 multi, level and hold-off pulses
    addVec(16'h0000, 16'h0080, 1'b0, 4'd0,  16'h0081);
    addVec(16'h0000, 16'h0000, 1'b0, 4'd0,  16'h0081);
    addVec(16'h0000, 16'h0000, 1'b1, 4'd7,  16'h0001);
    addVec(16'h0000, 16'h0010, 1'b1, 4'd4,  16'h0011);
    addVec(16'h0000, 16'h0000, 1'b0, 4'd0,  16'h0011);
    addVec(16'h0000, 16'h0000, 1'b1, 4'd4,  16'h0001);
    addVec(16'h0000, 16'h0000, 1'b1, 4'd0,  16'h0001);
    addVec(16'h0000, 16'h0000, 1'b0, 4'd0,  16'h0001);
    addVec(16'h0000, 16'h8002, 1'b0, 4'd0,  16'h8003);
    addVec(16'h0000, 16'h0000, 1'b1, 4'd15, 16'h0003);
    addVec(16'h0000, 16'h0000, 1'b1, 4'd1,  16'h0001);
    addVec(16'h0200, 16'h0000, 1'b0, 4'd0,  16'h0201);
    addVec(16'h0200, 16'h0000, 1'b1, 4'd9,  16'h0001);
    addVec(16'h0200, 16'h0000, 1'b0, 4'd0,  16'h0001);
    addVec(16'h0200, 16'h0000, 1'b0, 4'd0,  16'h0001);
    addVec(16'h0200, 16'h0000, 1'b0, 4'd0,  16'h0201);
    addVec(16'h0000, 16'h0000, 1'b0, 4'd0,  16'h0001);
    addVec(16'h0200, 16'h0000, 1'b1, 4'd9,  16'h0001);
    addVec(16'h0000, 16'h0200, 1'b0, 4'd0,  16'h0201);
    addVec(16'h0000, 16'h0000, 1'b0, 4'd0,  16'h0201);
    addVec(16'h0000, 16'h0000, 1'b1, 4'd9,  16'h0001);

    for (int i = 0; i < vectors.size(); i++) begin
      applyStimulus(vectors[i].level, vectors[i].pulse, vectors[i].blk, vectors[i].tsk);
      checkOutput($sformatf("vec%0d", i), vectors[i].expVec, vectors[i].expAny);
    end

    // T3: level on task 3 held through BLOCK, then a BLOCK re-issued in hold-off
    applyStimulus(16'h0008, 16'h0000, 1'b0, 4'd0);
    checkOutput("t3_level_on", 16'h0009, 1'b1);
    applyStimulus(16'h0008, 16'h0000, 1'b1, 4'd3);
    checkOutput("t3_block", 16'h0001, 1'b0);
    applyStimulus(16'h0008, 16'h0000, 1'b0, 4'd0);
    checkOutput("t3_hold1", 16'h0001, 1'b0);
    applyStimulus(16'h0008, 16'h0000, 1'b0, 4'd0);
    checkOutput("t3_hold2", 16'h0001, 1'b0);
    applyStimulus(16'h0008, 16'h0000, 1'b0, 4'd0);
    checkOutput("t3_reappear", 16'h0009, 1'b1);
    applyStimulus(16'h0008, 16'h0000, 1'b1, 4'd3);
    checkOutput("t3_reblock", 16'h0001, 1'b0);
    applyStimulus(16'h0008, 16'h0000, 1'b0, 4'd0);
    checkOutput("t3_rb_hold1", 16'h0001, 1'b0);
    applyStimulus(16'h0008, 16'h0000, 1'b1, 4'd3);
    checkOutput("t3_reload", 16'h0001, 1'b0);
    applyStimulus(16'h0008, 16'h0000, 1'b0, 4'd0);
    checkOutput("t3_reload_hold1", 16'h0001, 1'b0);
    applyStimulus(16'h0008, 16'h0000, 1'b0, 4'd0);
    checkOutput("t3_reload_hold2", 16'h0001, 1'b0);
    applyStimulus(16'h0008, 16'h0000, 1'b0, 4'd0);
    checkOutput("t3_reload_reappear", 16'h0009, 1'b1);

    // Randomized traffic against the model, with occasional async resets
    for (int c = 0; c < 600; c++) begin
      rl = 16'($urandom & $urandom & $urandom);
      rp = 16'($urandom & $urandom & $urandom & $urandom);
      rb = ($urandom_range(0, 2) == 0);
      rt = 4'($urandom_range(0, 15));
      applyStimulus(rl, rp, rb, rt);
      checkOutput($sformatf("rand%0d", c), modelVec, |modelVec[15:1]);
      if ($urandom_range(0, 99) == 0) asyncReset($sformatf("rand_reset%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alto_control_wakeup
